// File: rtl/ace_snoop_if.sv
// rtl/ace_snoop_if.sv - snoop address/response/data, cache lookup and line data signals
interface ace_snoop_if #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64
);
  logic                 ac_valid_i;
  logic                 ac_ready_o;
  logic [AddrWidth-1:0] ac_addr_i;
  logic [3:0]           ac_snoop_i;
  logic [2:0]           ac_prot_i;
  logic                 cr_valid_o;
  logic                 cr_ready_i;
  logic [4:0]           cr_resp_o;
  logic                 cd_valid_o;
  logic                 cd_ready_i;
  logic [DataWidth-1:0] cd_data_o;
  logic                 cd_last_o;
  logic                 lu_valid_o;
  logic                 lu_ready_i;
  logic [AddrWidth-1:0] lu_addr_o;
  logic [1:0]           lu_op_o;
  logic                 lu_data_o;
  logic                 lu_rsp_valid_i;
  logic                 lu_hit_i;
  logic                 lu_dirty_i;
  logic                 lu_unique_i;
  logic                 dat_valid_i;
  logic                 dat_ready_o;
  logic [DataWidth-1:0] dat_data_i;

  modport slave (
    input  ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i, cr_ready_i, cd_ready_i,
           lu_ready_i, lu_rsp_valid_i, lu_hit_i, lu_dirty_i, lu_unique_i,
           dat_valid_i, dat_data_i,
    output ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
           lu_valid_o, lu_addr_o, lu_op_o, lu_data_o, dat_ready_o
  );

  modport master (
    output ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i, cr_ready_i, cd_ready_i,
           lu_ready_i, lu_rsp_valid_i, lu_hit_i, lu_dirty_i, lu_unique_i,
           dat_valid_i, dat_data_i,
    input  ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
           lu_valid_o, lu_addr_o, lu_op_o, lu_data_o, dat_ready_o
  );
endinterface

// File: rtl/ace_snoop_responder.sv
// rtl/ace_snoop_responder.sv - ACE snoop responder: cache lookup, CR response, CD line data
module ace_snoop_responder #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int LineBeats = 4
) (
  input logic        clk_i,
  input logic        rst_ni,
  ace_snoop_if.slave bus
);
  localparam int CntW = $clog2(LineBeats);
  localparam int OffW = $clog2(LineBeats * DataWidth / 8);
  localparam logic [CntW-1:0] LastBeat = CntW'(LineBeats - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_RSP, RESP, DATA, DRAIN} state_t;

  state_t               state;
  logic [3:0]           snoop;
  logic                 hit;
  logic [CntW-1:0]      cnt;
  logic                 ac_ready;
  logic                 lu_valid;
  logic [AddrWidth-1:0] lu_addr;
  logic [1:0]           lu_op;
  logic                 lu_data;
  logic                 cr_valid;
  logic [4:0]           cr_resp;

  logic                 dec_ok;
  logic [1:0]           dec_op;
  logic                 dec_data;
  logic [4:0]           rsp;

  always_comb begin
    dec_ok   = 1'b1;
    dec_op   = 2'd0;
    dec_data = 1'b1;
    case (bus.ac_snoop_i)
      4'b0000:                   dec_op = 2'd0;
      4'b0001, 4'b0010, 4'b0011: dec_op = 2'd1;
      4'b0111, 4'b1001:          dec_op = 2'd3;
      4'b1000:                   dec_op = 2'd2;
      4'b1101: begin
        dec_op   = 2'd3;
        dec_data = 1'b0;
      end
      default:                   dec_ok = 1'b0;
    endcase
  end

  // Response bits: {WasUnique, IsShared, PassDirty, Error, DataTransfer}
  always_comb begin
    rsp = 5'b00000;
    if (bus.lu_hit_i) begin
      case (snoop)
        4'b0000, 4'b0001, 4'b0010, 4'b0011: rsp = {bus.lu_unique_i, 1'b1, 1'b0, 1'b0, 1'b1};
        4'b0111, 4'b1001: rsp = {bus.lu_unique_i, 1'b0, bus.lu_dirty_i, 1'b0, 1'b1};
        4'b1000:          rsp = {bus.lu_unique_i, 1'b1, bus.lu_dirty_i, 1'b0, bus.lu_dirty_i};
        default:          rsp = {bus.lu_unique_i, 4'b0000};
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      snoop    <= 4'd0;
      hit      <= 1'b0;
      cnt      <= '0;
      ac_ready <= 1'b1;
      lu_valid <= 1'b0;
      lu_addr  <= '0;
      lu_op    <= 2'd0;
      lu_data  <= 1'b0;
      cr_valid <= 1'b0;
      cr_resp  <= 5'd0;
    end else begin
      case (state)
        IDLE: if (bus.ac_valid_i) begin
          snoop    <= bus.ac_snoop_i;
          ac_ready <= 1'b0;
          if (dec_ok) begin
            lu_valid <= 1'b1;
            lu_addr  <= {bus.ac_addr_i[AddrWidth-1:OffW], OffW'(0)};
            lu_op    <= dec_op;
            lu_data  <= dec_data;
            state    <= LOOKUP;
          end else begin
            hit      <= 1'b0;
            cr_resp  <= 5'b00010;
            cr_valid <= 1'b1;
            state    <= RESP;
          end
        end
        LOOKUP: if (bus.lu_ready_i) begin
          lu_valid <= 1'b0;
          // A status pulse coincident with the accept is taken here directly
          if (bus.lu_rsp_valid_i) begin
            hit      <= bus.lu_hit_i;
            cr_resp  <= rsp;
            cr_valid <= 1'b1;
            state    <= RESP;
          end else begin
            state    <= WAIT_RSP;
          end
        end
        WAIT_RSP: if (bus.lu_rsp_valid_i) begin
          hit      <= bus.lu_hit_i;
          cr_resp  <= rsp;
          cr_valid <= 1'b1;
          state    <= RESP;
        end
        RESP: if (bus.cr_ready_i) begin
          cr_valid <= 1'b0;
          cnt      <= '0;
          if (cr_resp[0]) begin
            state <= DATA;
          end else if (hit && lu_data) begin
            state <= DRAIN;
          end else begin
            ac_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        DATA: if (bus.dat_valid_i && bus.cd_ready_i) begin
          cnt <= cnt + 1'b1;
          if (cnt == LastBeat) begin
            ac_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        DRAIN: if (bus.dat_valid_i) begin
          cnt <= cnt + 1'b1;
          if (cnt == LastBeat) begin
            ac_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ac_ready_o  = ac_ready;
  assign bus.lu_valid_o  = lu_valid;
  assign bus.lu_addr_o   = lu_addr;
  assign bus.lu_op_o     = lu_op;
  assign bus.lu_data_o   = lu_data;
  assign bus.cr_valid_o  = cr_valid;
  assign bus.cr_resp_o   = cr_resp;
  assign bus.cd_valid_o  = (state == DATA) && bus.dat_valid_i;
  assign bus.cd_data_o   = bus.dat_data_i;
  assign bus.cd_last_o   = (state == DATA) && (cnt == LastBeat);
  assign bus.dat_ready_o = (state == DATA) ? bus.cd_ready_i : (state == DRAIN);
endmodule

// File: tb/tb_ace_snoop_responder.sv
// tb/tb_ace_snoop_responder.sv - scoreboard bench for ace_snoop_responder
module tb_ace_snoop_responder;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LB = 4;
  localparam logic [AW-1:0] LineMask = AW'(LB * DW / 8 - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ace_snoop_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

  ace_snoop_responder #(.AddrWidth(AW), .DataWidth(DW), .LineBeats(LB)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int fails = 0;
  logic [AW+2:0] lu_q[$];
  logic [4:0]    cr_q[$];
  logic [DW:0]   cd_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    fails++;
    $display("FAIL %s: event seen/expired, required none", name);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: expectations derived from the ACSNOOP tables
  function automatic bit supported(input logic [3:0] c);
    return c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13};
  endfunction

  function automatic logic [1:0] model_op(input logic [3:0] c);
    if (c == 4'd0) return 2'd0;
    if (c <= 4'd3) return 2'd1;
    if (c == 4'd8) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [4:0] model_resp(input logic [3:0] c, input bit hit, input bit dirty,
                                            input bit uniq);
    bit dt, sh, pd;
    if (!supported(c)) return 5'b00010;
    if (!hit) return 5'b00000;
    dt = 0; sh = 0; pd = 0;
    if (c <= 4'd3) begin
      dt = 1; sh = 1;
    end else if (c == 4'd7 || c == 4'd9) begin
      dt = 1; pd = dirty;
    end else if (c == 4'd8) begin
      sh = 1; dt = dirty; pd = dirty;
    end
    return {uniq, sh, pd, 1'b0, dt};
  endfunction

  logic [AW+2:0] lu_e;
  logic [4:0]    cr_e;
  logic [DW:0]   cd_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.lu_valid_o && bus.lu_ready_i) begin
        if (lu_q.size() == 0) fail_event("lu_unexpected");
        else begin
          lu_e = lu_q.pop_front();
          check("lu_req", {bus.lu_addr_o, bus.lu_op_o, bus.lu_data_o}, lu_e);
        end
      end
      if (bus.cr_valid_o && bus.cr_ready_i) begin
        if (cr_q.size() == 0) fail_event("cr_unexpected");
        else begin
          cr_e = cr_q.pop_front();
          check("cr_resp", bus.cr_resp_o, cr_e);
        end
      end
      if (bus.cd_valid_o && cd_q.size() == 0) fail_event("cd_spurious");
      else if (bus.cd_valid_o && bus.cd_ready_i) begin
        cd_e = cd_q.pop_front();
        check("cd_beat", {bus.cd_last_o, bus.cd_data_o}, cd_e);
      end
    end
  end

  task automatic do_snoop(input logic [3:0] c, input logic [AW-1:0] a, input bit hit,
                          input bit dirty, input bit uniq, input bit toggle, input int abort_after);
    logic [4:0]    er;
    logic [DW-1:0] beat[LB];
    bit            streams, same, hs;
    int            n, i;
    er = model_resp(c, hit, dirty, uniq);
    streams = supported(c) && hit && (c != 4'd13);
    for (int k = 0; k < LB; k++) beat[k] = {$urandom, $urandom};
    if (supported(c)) lu_q.push_back({a & ~LineMask, model_op(c), c != 4'd13});
    cr_q.push_back(er);
    if (er[0]) for (int k = 0; k < LB; k++) cd_q.push_back({k == LB - 1, beat[k]});

    n = 0;
    while (!bus.ac_ready_o && n < 50) begin tick(); n++; end
    if (!bus.ac_ready_o) begin fail_event("ac_ready_timeout"); return; end
    bus.ac_valid_i = 1'b1;
    bus.ac_addr_i  = a;
    bus.ac_snoop_i = c;
    bus.ac_prot_i  = 3'($urandom);
    tick();
    bus.ac_valid_i = 1'b0;

    if (supported(c)) begin
      check("lu_latency", bus.lu_valid_o, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
      bus.lu_ready_i  = 1'b1;
      bus.lu_hit_i    = hit;
      bus.lu_dirty_i  = dirty;
      bus.lu_unique_i = uniq;
      same = 1'($urandom);
      bus.lu_rsp_valid_i = same;
      tick();
      bus.lu_ready_i = 1'b0;
      bus.lu_rsp_valid_i = 1'b0;
      if (!same) begin
        repeat ($urandom_range(0, 2)) tick();
        bus.lu_rsp_valid_i = 1'b1;
        tick();
        bus.lu_rsp_valid_i = 1'b0;
      end
      check("cr_latency", bus.cr_valid_o, 1'b1);
    end else begin
      check("cr_latency_unsup", {bus.cr_valid_o, bus.lu_valid_o}, 2'b10);
    end

    repeat ($urandom_range(0, 2)) tick();
    bus.cr_ready_i = 1'b1;
    tick();
    bus.cr_ready_i = 1'b0;

    if (!streams) begin
      check("ac_ready_after_cr", bus.ac_ready_o, 1'b1);
      return;
    end
    i = 0;
    n = 0;
    while (i < LB && n < 200) begin
      if (abort_after >= 0 && i == abort_after) break;
      bus.dat_valid_i = toggle ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.dat_data_i  = beat[i];
      bus.cd_ready_i  = toggle ? ~bus.cd_ready_i : 1'($urandom);
      #1;
      hs = bus.dat_valid_i && bus.dat_ready_o;
      tick();
      if (hs) i++;
      n++;
    end
    bus.dat_valid_i = 1'b0;
    bus.cd_ready_i  = 1'b0;
    if (abort_after >= 0) return;
    if (i < LB) fail_event("beat_timeout");
    else check("ac_ready_after_data", bus.ac_ready_o, 1'b1);
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {bus.ac_ready_o, bus.lu_valid_o, bus.cr_valid_o, bus.cd_valid_o, bus.dat_ready_o,
                 bus.cd_last_o, bus.cr_resp_o, bus.lu_addr_o, bus.lu_op_o, bus.lu_data_o},
          {1'b1, 5'b0, 5'b0, {AW{1'b0}}, 2'b0, 1'b0});
  endtask

  initial begin
    bus.ac_valid_i = 0; bus.ac_addr_i = '0; bus.ac_snoop_i = '0; bus.ac_prot_i = '0;
    bus.cr_ready_i = 0; bus.cd_ready_i = 0; bus.lu_ready_i = 0; bus.lu_rsp_valid_i = 0;
    bus.lu_hit_i = 0; bus.lu_dirty_i = 0; bus.lu_unique_i = 0;
    bus.dat_valid_i = 0; bus.dat_data_i = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    tick();
    check_idle_outputs("first_cycle_after_reset");

    do_snoop(4'b0001, 64'h1040, 1, 0, 0, 0, -1);
    do_snoop(4'b0111, 64'h2468, 1, 1, 1, 1, -1);
    do_snoop(4'b1000, 64'h3000, 1, 0, 0, 0, -1);
    do_snoop(4'b1101, 64'h4000, 0, 0, 0, 0, -1);
    do_snoop(4'b0100, 64'h5000, 0, 0, 0, 0, -1);

    do_snoop(4'b0001, 64'h6040, 1, 0, 1, 0, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cd_q.delete();
    check("abort_idle", {bus.ac_ready_o, bus.cd_valid_o, bus.cr_valid_o, bus.lu_valid_o}, 4'b1000);
    do_snoop(4'b0010, 64'h7088, 1, 1, 0, 0, -1);

    for (int t = 0; t < 40; t++)
      do_snoop(4'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), -1);

    repeat (5) tick();
    check("queues_drained", {32'(lu_q.size()), 32'(cr_q.size()), 32'(cd_q.size())}, 96'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end
endmodule
